fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pmips pipeline. It owns the program counter and drives the instruction-memory address. It captures the fetched word into IF/ID and presents it to decode and to `hazard_ctrl` as `IFID`. It obeys `PCStall` from `hazard_ctrl` and accepts branch/jump redirects from the later stages, inserting NOP bubbles on a redirect.

## Interface
Parameters:
- `IW`, 16, instruction width.
- `AW`, 16, PC / instruction-memory address width (word-addressed).
- `RESET_PC`, 0, PC value after reset.
- `NOP`, 16'h0000, bubble encoding written to IF/ID on flush or fill.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous active-high reset
- `PCStall`  in  1  from `hazard_ctrl`; hold PC and IF/ID
- `BranchTaken`  in  1  redirect request from the resolving stage
- `BranchTarget`  in  AW  redirect address, sampled when `BranchTaken`=1
- `imemaddr`  out  AW  instruction-memory address, equal to PC (combinational read memory)
- `imemrdata`  in  IW  instruction word at `imemaddr`, same cycle
- `IFID`  out  IW  IF/ID instruction register
- `IFIDPC`  out  AW  PC+1 of the instruction in `IFID`
- `IFIDValid`  out  1  `IFID` holds a real instruction, not a bubble
- `StallCount`  out  16  saturating count of cycles held by `PCStall`
- `FlushCount`  out  16  saturating count of redirects taken

## Operation
- FSM states: FILL, RUN, HOLD. Reset enters FILL.
- Priority for each cycle: `reset` > `BranchTaken` > `PCStall` > normal advance.
- Reset:
  - PC=`RESET_PC`; `IFID`=`NOP`; `IFIDPC`=0; `IFIDValid`=0.
  - Both counters=0; state=FILL.
- FILL: for exactly one cycle, PC is presented and nothing is held.
  - Next edge: capture `imemrdata` into IF/ID with Valid=1, PC←PC+1, go to RUN.
  - `PCStall` in FILL is ignored.
- RUN, normal advance:
  - `IFID`←`imemrdata`; `IFIDPC`←PC+1; Valid←1; PC←PC+1.
- RUN/HOLD with `PCStall`=1 and no branch:
  - PC, `IFID`, `IFIDPC` and Valid are all held.
  - `StallCount`+1, saturating at 16'hFFFF.
  - State becomes HOLD.
- HOLD with `PCStall`=0: normal advance, back to RUN. HOLD differs from RUN only for debug visibility.
- `BranchTaken`=1 in any non-reset state:
  - PC←`BranchTarget`; `IFID`←`NOP`; Valid←0; `IFIDPC`←0.
  - `FlushCount`+1, saturating.
  - Next state is FILL. The wrong-path word at the old PC is discarded.
  - `PCStall` is ignored that cycle.
- PC arithmetic is modulo 2^AW: 16'hFFFF+1 wraps to 0 with no flag.
- `imemaddr` is always the current PC register; it never depends on `PCStall` combinationally.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: the word addressed in cycle n appears on `IFID` after edge n+1.
- After reset deasserts at edge r:
  - first valid `IFID` = mem[`RESET_PC`] after edge r+1;
  - then mem[`RESET_PC`+1] after edge r+2.
- Redirect penalty: after the edge sampling `BranchTaken`, one bubble cycle (Valid=0). The target instruction appears valid one edge later.
- Stall is registered-hold only. Asserting `PCStall` for k cycles delays the stream by exactly k cycles with no loss or duplication.
- Reset asserted mid-stall or mid-FILL overrides everything at that edge.
- Counters update on the same edge as the triggering event.

## Structure
- Shared package `pmips_pkg`:
  - `IW`, `AW`, `NOP` encoding;
  - FSM state enum (`FETCH_FILL`, `FETCH_RUN`, `FETCH_HOLD`);
  - `sat_inc16` function, shared with other perf counters.
- Natural sub-module: `ifid_reg`, holding the instruction/PC/valid triple with hold and flush inputs.
- `fetch_stage` keeps the PC, the FSM and the counters.

## Test plan
- Reset with `RESET_PC`=0 and mem[i]=16'h1000+i, then release:
  - `IFID` shows `NOP` with Valid=0, then 16'h1000 with `IFIDPC`=1, then 16'h1001 with `IFIDPC`=2.
- `PCStall`=1 for 3 cycles while `IFID`=16'h1004:
  - `IFID` holds 16'h1004 and `imemaddr` holds 5 for 3 cycles;
  - 16'h1005 follows; `StallCount`=3.
- `BranchTaken`=1 with `BranchTarget`=16'h0040 while PC=8:
  - next cycle `IFID`=`NOP` with Valid=0 and `imemaddr`=16'h0040;
  - following cycle `IFID`=mem[16'h40] with Valid=1; `FlushCount`=1.
- `BranchTaken` and `PCStall` both 1 in the same cycle: redirect wins, `StallCount` unchanged, behaviour identical to the previous scenario.
- PC preset near the top via a branch to 16'hFFFE, run 3 cycles: `imemaddr` sequence FFFE, FFFF, 0000; `IFIDPC` wraps to 0.
- `reset` asserted during a 5-cycle stall with `StallCount`=2: next edge all outputs return to reset values and state is FILL; stall is ignored in FILL.

Source files
------------

// File: rtl/pmips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmips_pkg
//  Description : Shared pmips pipeline definitions: widths, bubble encoding,
//                fetch FSM states and the saturating perf-counter increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package pmips_pkg;

    localparam int          PMIPS_IW  = 16;
    localparam int          PMIPS_AW  = 16;
    localparam logic [15:0] PMIPS_NOP = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_FILL = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    // Perf counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage : pmips_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Fetch-stage bundle: hazard/redirect controls, instruction
//                memory port, IF/ID outputs and perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int IW = 16,
    parameter int AW = 16
);
    logic          PCStall;
    logic          BranchTaken;
    logic [AW-1:0] BranchTarget;
    logic [AW-1:0] imemaddr;
    logic [IW-1:0] imemrdata;
    logic [IW-1:0] IFID;
    logic [AW-1:0] IFIDPC;
    logic          IFIDValid;
    logic [15:0]   StallCount;
    logic [15:0]   FlushCount;

    // Fetch stage side
    modport master (
        input  PCStall, BranchTaken, BranchTarget, imemrdata,
        output imemaddr, IFID, IFIDPC, IFIDValid, StallCount, FlushCount
    );

    // Surrounding pipeline / memory side
    modport slave (
        output PCStall, BranchTaken, BranchTarget, imemrdata,
        input  imemaddr, IFID, IFIDPC, IFIDValid, StallCount, FlushCount
    );
endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register holding instruction, PC+1 and valid.
//                Flush loads a bubble; hold freezes the triple.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import pmips_pkg::*;
#(
    parameter int            IW  = PMIPS_IW,
    parameter int            AW  = PMIPS_AW,
    parameter logic [IW-1:0] NOP = PMIPS_NOP
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_hold,
    input  wire logic          i_flush,
    input  wire logic [IW-1:0] i_instr,
    input  wire logic [AW-1:0] i_pc,
    output logic      [IW-1:0] o_instr,
    output logic      [AW-1:0] o_pc,
    output logic               o_valid
);

    logic [IW-1:0] r_instr;
    logic [AW-1:0] r_pc;
    logic          r_valid;

    // Flush beats hold; a bubble carries PC 0 so it is easy to spot in traces.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr <= NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : pmips instruction fetch: PC, FILL/RUN/HOLD sequencing,
//                redirect flush, stall hold and saturating perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import pmips_pkg::*;
#(
    parameter int            IW       = PMIPS_IW,
    parameter int            AW       = PMIPS_AW,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [IW-1:0] NOP      = PMIPS_NOP
) (
    input  wire logic     clock,
    input  wire logic     reset,
    fetch_stage_if.master bus
);

    fetch_state_e  r_state;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_stall_cnt;
    logic [15:0]   r_flush_cnt;

    logic          w_redirect;
    logic          w_stall;
    logic [AW-1:0] w_pc_inc;
    logic [IW-1:0] w_ifid;
    logic [AW-1:0] w_ifid_pc;
    logic          w_ifid_valid;

    // A stall only counts outside FILL and loses to a redirect.
    assign w_redirect = bus.BranchTaken;
    assign w_stall    = bus.PCStall && !w_redirect && (r_state != FETCH_FILL);
    assign w_pc_inc   = r_pc + {{(AW-1){1'b0}}, 1'b1};

    // PC, state and counters advance together under the per-cycle priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= FETCH_FILL;
            r_pc        <= RESET_PC;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else if (w_redirect) begin
            r_state     <= FETCH_FILL;
            r_pc        <= bus.BranchTarget;
            r_flush_cnt <= sat_inc16(r_flush_cnt);
        end else if (w_stall) begin
            r_state     <= FETCH_HOLD;
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end else begin
            r_state     <= FETCH_RUN;
            r_pc        <= w_pc_inc;
        end
    end

    ifid_reg #(
        .IW  (IW),
        .AW  (AW),
        .NOP (NOP)
    ) u_ifid_reg (
        .clk     (clock),
        .rst     (reset),
        .i_hold  (w_stall),
        .i_flush (w_redirect),
        .i_instr (bus.imemrdata),
        .i_pc    (w_pc_inc),
        .o_instr (w_ifid),
        .o_pc    (w_ifid_pc),
        .o_valid (w_ifid_valid)
    );

    assign bus.imemaddr   = r_pc;
    assign bus.IFID       = w_ifid;
    assign bus.IFIDPC     = w_ifid_pc;
    assign bus.IFIDValid  = w_ifid_valid;
    assign bus.StallCount = r_stall_cnt;
    assign bus.FlushCount = r_flush_cnt;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: directed scenarios with
//                literal expectations, then randomized traffic against a
//                stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk;
    logic rst;

    fetch_stage_if #(.IW(16), .AW(16)) bus ();

    fetch_stage #(
        .IW       (16),
        .AW       (16),
        .RESET_PC (16'h0000),
        .NOP      (16'h0000)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Instruction memory contents: mem[a] = 16'h1000 + a
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    assign bus.imemrdata = mem_word(bus.imemaddr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks the stream: the PC being fetched, what sits in IF/ID,
    // and whether the next edge is a forced fill (stall not honoured).
    logic [15:0] m_pc, m_ifid, m_ifidpc, m_sc, m_fc;
    logic        m_valid, m_fill;
    bit          m_ok = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 16'h0000; m_ifid = 16'h0000; m_ifidpc = 16'h0000; m_valid = 1'b0;
            m_sc = 16'h0000; m_fc = 16'h0000; m_fill = 1'b1; m_ok = 1;
        end else if (m_ok) begin
            if (bus.BranchTaken) begin
                m_pc = bus.BranchTarget;
                m_ifid = 16'h0000; m_ifidpc = 16'h0000; m_valid = 1'b0;
                if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
                m_fill = 1'b1;
            end else if (bus.PCStall && !m_fill) begin
                if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            end else begin
                m_ifid   = mem_word(m_pc);
                m_ifidpc = m_pc + 16'd1;
                m_valid  = 1'b1;
                m_pc     = m_pc + 16'd1;
                m_fill   = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_ok) begin
            chk("imemaddr",   {16'h0, bus.imemaddr},   {16'h0, m_pc});
            chk("IFID",       {16'h0, bus.IFID},       {16'h0, m_ifid});
            chk("IFIDPC",     {16'h0, bus.IFIDPC},     {16'h0, m_ifidpc});
            chk("IFIDValid",  {31'h0, bus.IFIDValid},  {31'h0, m_valid});
            chk("StallCount", {16'h0, bus.StallCount}, {16'h0, m_sc});
            chk("FlushCount", {16'h0, bus.FlushCount}, {16'h0, m_fc});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
        rst = r; bus.PCStall = s; bus.BranchTaken = b; bus.BranchTarget = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string tag, input logic [15:0] ifid, input logic [15:0] ifidpc,
                       input logic valid, input logic [15:0] addr);
        chk({tag, ".IFID"},   {16'h0, bus.IFID},     {16'h0, ifid});
        chk({tag, ".IFIDPC"}, {16'h0, bus.IFIDPC},   {16'h0, ifidpc});
        chk({tag, ".Valid"},  {31'h0, bus.IFIDValid}, {31'h0, valid});
        chk({tag, ".addr"},   {16'h0, bus.imemaddr}, {16'h0, addr});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bus.PCStall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = 16'h0;
        @(negedge clk);

        // Reset and fill
        step(1, 0, 0, 0);
        lit("rst", 16'h0000, 16'h0000, 0, 16'h0000);
        chk("rst.StallCount", {16'h0, bus.StallCount}, 32'h0);
        chk("rst.FlushCount", {16'h0, bus.FlushCount}, 32'h0);
        step(0, 0, 0, 0);
        lit("fill0", 16'h1000, 16'h0001, 1, 16'h0001);
        step(0, 0, 0, 0);
        lit("fill1", 16'h1001, 16'h0002, 1, 16'h0002);
        repeat (3) step(0, 0, 0, 0);
        lit("pre_stall", 16'h1004, 16'h0005, 1, 16'h0005);

        // Three-cycle stall while IFID = 16'h1004
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            lit("stall", 16'h1004, 16'h0005, 1, 16'h0005);
        end
        step(0, 0, 0, 0);
        lit("post_stall", 16'h1005, 16'h0006, 1, 16'h0006);
        chk("stall.StallCount", {16'h0, bus.StallCount}, 32'd3);
        repeat (2) step(0, 0, 0, 0);

        // Redirect at PC = 8
        chk("pc8", {16'h0, bus.imemaddr}, 32'h8);
        step(0, 0, 1, 16'h0040);
        lit("br_bubble", 16'h0000, 16'h0000, 0, 16'h0040);
        step(0, 0, 0, 0);
        lit("br_target", 16'h1040, 16'h0041, 1, 16'h0041);
        chk("br.FlushCount", {16'h0, bus.FlushCount}, 32'd1);

        // Redirect and stall together: redirect wins, stall not counted
        step(0, 1, 1, 16'h0040);
        lit("brst_bubble", 16'h0000, 16'h0000, 0, 16'h0040);
        chk("brst.StallCount", {16'h0, bus.StallCount}, 32'd3);
        step(0, 0, 0, 0);
        lit("brst_target", 16'h1040, 16'h0041, 1, 16'h0041);
        chk("brst.FlushCount", {16'h0, bus.FlushCount}, 32'd2);

        // PC wrap at the top of the address space
        step(0, 0, 1, 16'hFFFE);
        chk("wrap.addr0", {16'h0, bus.imemaddr}, 32'hFFFE);
        step(0, 0, 0, 0);
        lit("wrap1", 16'h0FFE, 16'hFFFF, 1, 16'hFFFF);
        step(0, 0, 0, 0);
        lit("wrap2", 16'h0FFF, 16'h0000, 1, 16'h0000);
        step(0, 0, 0, 0);
        lit("wrap3", 16'h1000, 16'h0001, 1, 16'h0001);

        // Reset in the middle of a stall, then stall ignored in FILL
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        chk("mid.StallCount", {16'h0, bus.StallCount}, 32'd2);
        step(1, 1, 0, 0);
        lit("mid_rst", 16'h0000, 16'h0000, 0, 16'h0000);
        chk("mid_rst.StallCount", {16'h0, bus.StallCount}, 32'd0);
        step(0, 1, 0, 0);
        lit("fill_nostall", 16'h1000, 16'h0001, 1, 16'h0001);
        chk("fill_nostall.StallCount", {16'h0, bus.StallCount}, 32'd0);
        step(0, 1, 0, 0);
        lit("hold_after_fill", 16'h1000, 16'h0001, 1, 16'h0001);
        chk("hold_after_fill.StallCount", {16'h0, bus.StallCount}, 32'd1);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                              : 16'($urandom_range(0, 65535));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0),
                 tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
